osecpu_debug_port: RTL

- Parametrised successor to the single CPDR debug register in the OSECPU top.
- Snoops the decoded instruction and controller state. On each CPDR execute it captures the integer-register read value into one of NCH per-channel debug registers, selected by the instruction.
- Also pushes the value, tagged with its channel, into a FIFO that a host or UART bridge drains with a valid/ready handshake.
- Adds overflow detection, a drop counter and bad-channel reporting, none of which the single-register version had.

---
 rtl/osecpu_debug_port_pkg.sv | 19 +
 rtl/osecpu_sync_fifo.sv | 70 +++++++
 rtl/osecpu_debug_port.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/osecpu_debug_port_pkg.sv
// Shared controller definitions and capture decode helper for the OSECPU debug port.
package osecpu_debug_port_pkg;

  // Controller state in which the decoded instruction is being executed.
  localparam logic [3:0] STATE_EXEC  = 4'd2;

  // Opcode of the CPDR (copy-to-debug-register) instruction.
  localparam logic [7:0] CPDR_OPCODE = 8'hD3;

  // True when the instruction word carries the given opcode while the controller executes.
  function automatic logic is_capture(
    input logic [31:0] instr,
    input logic [3:0]  state,
    input logic [7:0]  opcode
  );
    return (instr[31:24] == opcode) && (state == STATE_EXEC);
  endfunction

endpackage

// File: rtl/osecpu_sync_fifo.sv
// Synchronous first-word fall-through FIFO with extra-MSB pointers.
// A push while full is accepted only when a pop happens in the same cycle.
module osecpu_sync_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         push_ok_s;
  logic         pop_ok_s;

  // Status flags and head entry, all derived from registered pointers and storage.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    if (empty) begin
      head = {W{1'b0}};
    end else begin
      head = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  // Accept/advance decisions; pop frees a slot for a same-cycle push when full.
  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; reset discards any stored entries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array write; contents are don't-care while the slot is outside the pointers.
  always_ff @(posedge clk) begin
    if (reset && push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/osecpu_debug_port.sv
// OSECPU debug port: per-channel CPDR capture registers plus a tagged capture FIFO
// with overflow, drop counting and bad-channel reporting.
module osecpu_debug_port
  import osecpu_debug_port_pkg::*;
#(
  parameter int         DW      = 32,
  parameter int         NCH     = 4,
  parameter int         CHW     = 2,
  parameter int         DEPTH   = 16,
  parameter logic [7:0] CPDR_OP = CPDR_OPCODE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr0,
  input  logic [3:0]        current_state,
  input  logic [DW-1:0]     ireg_d0,
  output logic [NCH*DW-1:0] dr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [CHW-1:0]    out_ch,
  output logic              overflow,
  output logic              bad_ch,
  output logic [15:0]       drop_count,
  input  logic              clr_err
);

  localparam logic [31:0] NCH_L = NCH;

  logic [DW-1:0]     dr_q [NCH];
  logic [DW-1:0]     dr_d [NCH];
  logic              overflow_q, overflow_d;
  logic              bad_ch_q, bad_ch_d;
  logic [15:0]       drop_count_q, drop_count_d;

  logic              cap_s;
  logic [CHW-1:0]    ch_s;
  logic [31:0]       ch_ext_s;
  logic              cap_ok_s;
  logic              cap_bad_s;
  logic              drop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [DW+CHW-1:0] fifo_head_s;

  // Capture decode: strobe, channel select and channel range check.
  always_comb begin
    cap_s     = is_capture(instr0, current_state, CPDR_OP);
    ch_s      = instr0[CHW-1:0];
    ch_ext_s  = {{(32-CHW){1'b0}}, ch_s};
    cap_ok_s  = cap_s && (ch_ext_s < NCH_L);
    cap_bad_s = cap_s && !(ch_ext_s < NCH_L);
    // A full FIFO with a non-empty head being popped can still take the push.
    drop_s    = cap_ok_s && fifo_full_s && !out_ready;
  end

  osecpu_sync_fifo #(
    .W     (DW + CHW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cap_ok_s),
    .din   ({ch_s, ireg_d0}),
    .pop   (out_ready),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .head  (fifo_head_s)
  );

  // Debug register bank next-state: only the selected valid channel takes the value.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      if (cap_ok_s && (ch_ext_s == k)) begin
        dr_d[k] = ireg_d0;
      end else begin
        dr_d[k] = dr_q[k];
      end
    end
  end

  // Error flag and drop counter next-state; a new event wins over a coincident clear.
  always_comb begin
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    if (cap_bad_s) begin
      bad_ch_d = 1'b1;
    end else if (clr_err) begin
      bad_ch_d = 1'b0;
    end else begin
      bad_ch_d = bad_ch_q;
    end

    if (clr_err) begin
      drop_count_d = drop_s ? 16'd1 : 16'd0;
    end else if (drop_s && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  // State registers for the debug bank, flags and drop counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NCH; k++) begin
        dr_q[k] <= {DW{1'b0}};
      end
      overflow_q   <= 1'b0;
      bad_ch_q     <= 1'b0;
      drop_count_q <= 16'd0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        dr_q[k] <= dr_d[k];
      end
      overflow_q   <= overflow_d;
      bad_ch_q     <= bad_ch_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Output mapping: flattened debug bank and FIFO head fields.
  always_comb begin
    dr = {(NCH*DW){1'b0}};
    for (int k = 0; k < NCH; k++) begin
      dr[k*DW +: DW] = dr_q[k];
    end
    out_valid  = !fifo_empty_s;
    out_data   = fifo_head_s[DW-1:0];
    out_ch     = fifo_head_s[DW+CHW-1:DW];
    overflow   = overflow_q;
    bad_ch     = bad_ch_q;
    drop_count = drop_count_q;
  end

endmodule
